// File: rtl/tdm_mult_scheduler.sv
// Time-division scheduler sharing one pipelined multiplier among NUM_REQ requesters, with tagged responses and halt/drain.
// Optional macro MULT_SCHED_STRICT_TDM_EN selects a fixed slot schedule instead of work-conserving round robin.
module tdm_mult_scheduler #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned MULT_LATENCY = 1,
  parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic                          halt_req_i,
  output logic                          halted_o,
  output logic [DATA_WIDTH-1:0]         mult_a_o,
  output logic [DATA_WIDTH-1:0]         mult_b_o,
  output logic                          mult_valid_o,
  input  logic [2*DATA_WIDTH-1:0]       mult_p_i,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [2*DATA_WIDTH-1:0]       rsp_data_o
);

  localparam int unsigned     PW       = 2 * DATA_WIDTH;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    grant_en;
  logic                    gnt_found;
  logic [ID_W-1:0]         gnt_idx;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;
  logic [DATA_WIDTH-1:0]   mult_a_q, mult_b_q;
  logic                    mult_valid_q;
  logic [ID_W-1:0]         iss_id_q;
  logic [MULT_LATENCY-1:0] pv_q;
  logic [ID_W-1:0]         pid_q [MULT_LATENCY];
  logic                    rsp_valid_q;
  logic [ID_W-1:0]         rsp_id_q;
  logic [PW-1:0]           rsp_data_q;
  logic                    halted_q;
  logic                    pipe_empty;

  assign pipe_empty = (pv_q == '0) && !mult_valid_q;

  // FSM next state; grants are only possible in RUN with no halt request.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      ST_RUN: begin
        grant_en = !halt_req_i;
        if (halt_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (pipe_empty) state_d = ST_HALTED;
      ST_HALTED: if (!halt_req_i) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

`ifdef MULT_SCHED_STRICT_TDM_EN
  logic [ID_W-1:0] slot_q, slot_d;

  // Free-running slot: only the slot owner may be granted; empty slots are wasted.
  always_comb begin
    slot_d    = (slot_q == LAST_IDX) ? '0 : slot_q + ID_W'(1);
    gnt_idx   = slot_q;
    gnt_found = grant_en && req_valid_i[slot_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;

  // Work-conserving round robin: first valid index at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr_q) + off >= NUM_REQ) ? ID_W'(32'(ptr_q) + off - NUM_REQ)
                                           : ID_W'(32'(ptr_q) + off);
      if (grant_en && !gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    ptr_d = ptr_q;
    if (gnt_found) ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // One-hot ready and operand mux; operands hold when nothing is granted.
  always_comb begin
    req_ready_o = '0;
    sel_a       = mult_a_q;
    sel_b       = mult_b_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && gnt_idx == ID_W'(i)) begin
        req_ready_o[i] = 1'b1;
        sel_a          = req_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b          = req_b_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Issue stage, tag pipeline tracking the multiplier latency, and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_valid_q <= 1'b0;
      iss_id_q     <= '0;
      pv_q         <= '0;
      for (int unsigned i = 0; i < MULT_LATENCY; i++) pid_q[i] <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      halted_q     <= 1'b0;
    end else begin
      mult_valid_q <= gnt_found;
      mult_a_q     <= sel_a;
      mult_b_q     <= sel_b;
      if (gnt_found) iss_id_q <= gnt_idx;
      pv_q[0]  <= mult_valid_q;
      pid_q[0] <= iss_id_q;
      for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
      rsp_valid_q <= pv_q[MULT_LATENCY-1];
      if (pv_q[MULT_LATENCY-1]) begin
        rsp_id_q   <= pid_q[MULT_LATENCY-1];
        rsp_data_q <= mult_p_i;
      end
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign mult_a_o     = mult_a_q;
  assign mult_b_o     = mult_b_q;
  assign mult_valid_o = mult_valid_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_data_o   = rsp_data_q;
  assign halted_o     = halted_q;

endmodule

// File: doc/tdm_mult_scheduler.md
Name: tdm_mult_scheduler

Overview:
Shares one pipelined DSP multiplier among NUM_REQ requesters in time-division fashion.
- Each requester presents an operand pair with a valid/ready handshake.
- The scheduler grants at most one per cycle, round-robin, and drives the shared multiplier's inputs.
- It tags each issue with the requester ID and tracks it through the multiplier latency, so results leave on a single tagged response bus.
- A halt/drain controller lets software quiesce the datapath cleanly.

Parameters:
DATA_WIDTH, 8, operand width; product width is 2*DATA_WIDTH
NUM_REQ, 2, number of requesters (>=2)
MULT_LATENCY, 1, cycles from mult_a/mult_b registered to mult_p valid (>=1)
ID_W, $clog2(NUM_REQ), response tag width

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_a  in  NUM_REQ*DATA_WIDTH  packed; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_b  in  NUM_REQ*DATA_WIDTH  packed as req_a
halt_req  in  1  request to stop issuing and drain
halted  out  1  high when no grants are possible and the pipeline is empty
mult_a  out  DATA_WIDTH  registered operand A to shared multiplier
mult_b  out  DATA_WIDTH  registered operand B to shared multiplier
mult_valid  out  1  registered issue strobe aligned with mult_a/mult_b
mult_p  in  2*DATA_WIDTH  multiplier product
rsp_valid  out  1  registered result valid (no backpressure)
rsp_id  out  ID_W  requester that owns rsp_data
rsp_data  out  2*DATA_WIDTH  registered product

Behaviour:
- Reset (async assert, sync release): state=RUN, rr pointer=0, all tag/valid pipeline stages cleared; mult_a=mult_b=0, mult_valid=0, rsp_valid=0, rsp_id=0, rsp_data=0, halted=0.
- Transfer occurs at the edge where req_valid[i]&req_ready[i].
- req_ready is combinational from req_valid, the pointer and the state.
- Never more than one bit of req_ready is set.
- Grant is allowed only in RUN with halt_req=0.
- Arbitration (default):
  - Work-conserving round robin. Search starts at pointer p; the first valid index in p, p+1, …, wrapping modulo NUM_REQ, is granted.
  - After a grant to i, p <= (i+1) mod NUM_REQ.
  - With no grant, p is unchanged.
- Issue: on a transfer from i at edge k:
  - mult_a, mult_b and mult_valid=1 update at edge k.
  - tag i enters a MULT_LATENCY-deep shift register alongside valid.
  - With no transfer, mult_valid=0 and mult_a/mult_b hold their last values.
- Response: at edge k+MULT_LATENCY+1, rsp_valid=1, rsp_id=i and rsp_data=mult_p (sampled while the tag pipeline output is valid).
  - Total accept-to-response latency is MULT_LATENCY+1 cycles.
  - Throughput is one result per cycle.
  - rsp_data/rsp_id hold their last values when rsp_valid=0.
- In-flight count = number of set valid bits in the tag pipeline plus mult_valid, 0..MULT_LATENCY+1.
- FSM:
  - RUN: grants allowed. If halt_req=1, no grant is given that cycle and the next state is DRAIN.
  - DRAIN: no grants. When in-flight=0, go to HALTED. halt_req may drop during DRAIN; the drain still completes.
  - HALTED: halted=1, no grants. When halt_req=0, go to RUN; halted drops the same edge.
- halt_req asserted with nothing in flight: DRAIN lasts one cycle, then HALTED.
- Requests pending during DRAIN/HALTED wait; their valid stays high and no data is lost.
- Reset mid-operation: in-flight tags are discarded and rsp_valid falls immediately; no stale response appears after release.
- Widths: product is unsigned 2*DATA_WIDTH with no truncation; the pointer wraps at NUM_REQ (non-power-of-2 NUM_REQ is supported).

Optional Feature:
MULT_SCHED_STRICT_TDM_EN
- Defined: fixed slot schedule.
  - A free-running slot counter advances 0..NUM_REQ-1 every cycle in all states and resets to 0.
  - Only requester == slot may be granted.
  - An empty slot is wasted, which gives deterministic per-requester bandwidth of 1/NUM_REQ.
  - The rr pointer is unused.
- Undefined: work-conserving round robin as above.

Test Plan:
- Hold rst_n=0, then release → all outputs 0, halted=0; first grant from pointer 0.
- NUM_REQ=2, MULT_LATENCY=1; only req0 valid, a=3, b=5, for 3 cycles → req_ready[0] every cycle; three responses id=0, data=15, each 2 cycles after accept, back to back.
- Both requesters valid continuously; req0 a=2,b=4; req1 a=255,b=255 → grants alternate 0,1,0,1; responses alternate data=8 id=0 / data=65025 id=1; no gap cycles.
- One transfer accepted at edge k, halt_req raised at k+1 → req_ready=0 from k+1; response arrives at k+2; halted=1 once in-flight=0; drop halt_req → grants resume the next cycle with the pointer preserved.
- Accept at edge k, pull rst_n low before k+2 → rsp_valid stays 0, no response after release, pointer=0.
- With MULT_SCHED_STRICT_TDM_EN, only req1 valid (a=7, b=9) → grants only in slot-1 cycles (every other cycle); responses data=63 id=1 every 2 cycles.
